// File: rtl/native_to_axi4lite_bridge.sv
// -----------------------------------------------------------------------------
// native_to_axi4lite_bridge
//
// Converts a native valid/ready memory port (one access in flight) into
// AXI4-lite master channels. Each native request produces exactly one AXI
// transaction (AR/R for reads, AW+W/B for writes) and one mem_ready pulse.
//
// Optional feature macro: AXI_BRIDGE_TIMEOUT_EN
//   Defined   : response watchdog. After TIMEOUT_CYCLES busy cycles the bridge
//               abandons the transfer, returns 32'hDEADBEEF with a mem_ready
//               pulse, raises the sticky bus_error and halts until reset.
//   Undefined : no watchdog, bus_error tied low, the bridge waits forever.
//
// Parameters
//   TIMEOUT_CYCLES  watchdog limit (only meaningful with the macro defined)
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb  native request (wstrb==0 means read)
//   mem_ready, mem_rdata            one-cycle completion pulse, read data
//   mem_axi_aw*, mem_axi_w*         write address / write data channels
//   mem_axi_b*                      write response channel
//   mem_axi_ar*, mem_axi_r*         read address / read data channels
//   bus_error                       sticky watchdog flag
// -----------------------------------------------------------------------------
module native_to_axi4lite_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_RESP = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
`ifdef AXI_BRIDGE_TIMEOUT_EN
    ,
    HALT    = 3'd6
`endif
  } state_t;

  state_t      state, state_d;

  logic        arvalid_d, awvalid_d, wvalid_d, bready_d, rready_d;
  logic [31:0] araddr_d, awaddr_d, wdata_d;
  logic [2:0]  arprot_d, awprot_d;
  logic [3:0]  wstrb_d;
  logic        mem_ready_d;
  logic [31:0] mem_rdata_d;

  // A write channel counts as finished once its valid has dropped or it is
  // handshaking this cycle; AW and W may complete in either order.
  logic        aw_done, w_done;

`ifdef AXI_BRIDGE_TIMEOUT_EN
  logic [31:0] wd_cnt, wd_cnt_d;
  logic        bus_error_d;
  logic        wd_busy, wd_hit;

  assign wd_busy = (state != IDLE) && (state != DONE) && (state != HALT);
  assign wd_hit  = wd_busy && (wd_cnt == TIMEOUT_CYCLES);
`else
  // Watchdog compiled out; the comparison only keeps the parameter referenced.
  assign bus_error = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  always_comb begin
    state_d     = state;
    arvalid_d   = mem_axi_arvalid;
    araddr_d    = mem_axi_araddr;
    arprot_d    = mem_axi_arprot;
    awvalid_d   = mem_axi_awvalid;
    awaddr_d    = mem_axi_awaddr;
    awprot_d    = mem_axi_awprot;
    wvalid_d    = mem_axi_wvalid;
    wdata_d     = mem_axi_wdata;
    wstrb_d     = mem_axi_wstrb;
    bready_d    = mem_axi_bready;
    rready_d    = mem_axi_rready;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata;
    aw_done     = 1'b0;
    w_done      = 1'b0;

    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (mem_wstrb == 4'b0000) begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = mem_addr;
            arprot_d  = {mem_instr, 2'b00};
          end else begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            awaddr_d  = mem_addr;
            awprot_d  = 3'b000;
            wvalid_d  = 1'b1;
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
          end
        end
      end

      RD_ADDR: begin
        if (mem_axi_arvalid && mem_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      WR_ADDR: begin
        aw_done = !mem_axi_awvalid || mem_axi_awready;
        w_done  = !mem_axi_wvalid  || mem_axi_wready;
        if (mem_axi_awvalid && mem_axi_awready) awvalid_d = 1'b0;
        if (mem_axi_wvalid  && mem_axi_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      RD_RESP: begin
        if (mem_axi_rvalid && mem_axi_rready) begin
          rready_d    = 1'b0;
          mem_rdata_d = mem_axi_rdata;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      WR_RESP: begin
        if (mem_axi_bvalid && mem_axi_bready) begin
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      // mem_valid is deliberately not looked at here: the core still holds it
      // high across the edge where it sees mem_ready.
      DONE: state_d = IDLE;

`ifdef AXI_BRIDGE_TIMEOUT_EN
      HALT: state_d = HALT;
`endif

      default: state_d = IDLE;
    endcase

`ifdef AXI_BRIDGE_TIMEOUT_EN
    wd_cnt_d    = wd_cnt;
    bus_error_d = bus_error;
    if (state == IDLE)
      wd_cnt_d = 32'd0;
    else if (wd_busy)
      wd_cnt_d = wd_cnt + 32'd1;

    if (wd_hit) begin
      arvalid_d   = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      mem_ready_d = 1'b1;
      mem_rdata_d = 32'hDEADBEEF;
      bus_error_d = 1'b1;
      state_d     = HALT;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      mem_axi_arvalid <= 1'b0;
      mem_axi_araddr  <= 32'd0;
      mem_axi_arprot  <= 3'd0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_awaddr  <= 32'd0;
      mem_axi_awprot  <= 3'd0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= 32'd0;
      mem_axi_wstrb   <= 4'd0;
      mem_axi_bready  <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_ready       <= 1'b0;
      mem_rdata       <= 32'd0;
`ifdef AXI_BRIDGE_TIMEOUT_EN
      wd_cnt          <= 32'd0;
      bus_error       <= 1'b0;
`endif
    end else begin
      state           <= state_d;
      mem_axi_arvalid <= arvalid_d;
      mem_axi_araddr  <= araddr_d;
      mem_axi_arprot  <= arprot_d;
      mem_axi_awvalid <= awvalid_d;
      mem_axi_awaddr  <= awaddr_d;
      mem_axi_awprot  <= awprot_d;
      mem_axi_wvalid  <= wvalid_d;
      mem_axi_wdata   <= wdata_d;
      mem_axi_wstrb   <= wstrb_d;
      mem_axi_bready  <= bready_d;
      mem_axi_rready  <= rready_d;
      mem_ready       <= mem_ready_d;
      mem_rdata       <= mem_rdata_d;
`ifdef AXI_BRIDGE_TIMEOUT_EN
      wd_cnt          <= wd_cnt_d;
      bus_error       <= bus_error_d;
`endif
    end
  end

endmodule
